// File: rtl/protected_regfile.sv
// protected_regfile
//   Register file with an immutable key region and per-entry write locks.
//   After reset an INIT sequence fills every entry (key words at indices
//   0..KEY_WORDS-1, zero elsewhere) and sets the lock bits of the key region.
//   In IDLE one request per cycle is accepted; reads return data one cycle
//   later, and rejected accesses (locked entry or out-of-range address) raise
//   a one-cycle err pulse.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset, restarts INIT
//   req        : request valid
//   write      : 1 = write, 0 = read
//   lock       : on a write, lock the entry after writing it
//   addr       : 32-bit word address
//   wdata      : write data
//   ready      : request accepted when req && ready
//   busy       : initialisation in progress
//   rvalid     : rdata valid this cycle
//   rdata      : read data (0 for an out-of-range read)
//   err        : one-cycle pulse for a rejected access
//   viol_count : saturating count of err pulses
//
// Optional feature
//   PROTECTED_REGFILE_VIOL_CNT_EN : when defined, viol_count counts err
//   pulses and saturates at 8'hFF; otherwise it is tied to 0.

module protected_regfile #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 32,
  parameter int          KEY_WORDS = 2,
  parameter logic [31:0] HASH_KEY  = 32'h1035_9987
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              write,
  input  logic              lock,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [7:0]        viol_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   KEY_LIMIT = (IDX_W + 1)'(KEY_WORDS);
  localparam logic [31:0]      DEPTH_W   = 32'(DEPTH);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic               rd_ok_q, rd_ok_d;   // read was in range, mem data is meaningful
  logic [DEPTH-1:0]   lock_q, lock_d;

  // Storage: plain array, written on one port, read through a register.
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  mem_rd_q;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;

  logic [IDX_W-1:0]   addr_idx;
  logic               in_range;
  logic               in_key;
  logic [31:0]        key_sum;

  // Full 32-bit compare so high address bits can never alias into the array.
  assign in_range = (addr < DEPTH_W);
  assign addr_idx = addr[IDX_W-1:0];
  assign in_key   = ({1'b0, idx_q} < KEY_LIMIT);
  assign key_sum  = HASH_KEY + 32'(idx_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rd_ok_d   = 1'b0;
    lock_d    = lock_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = '0;

    case (state_q)
      ST_INIT: begin
        mem_we        = 1'b1;
        mem_waddr     = idx_q;
        mem_wdata     = in_key ? DATA_W'(key_sum) : '0;
        lock_d[idx_q] = in_key;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (req) begin
          if (!in_range) begin
            err_d    = 1'b1;
            rvalid_d = !write;
          end else if (write) begin
            if (lock_q[addr_idx]) begin
              err_d = 1'b1;
            end else begin
              mem_we           = 1'b1;
              mem_waddr        = addr_idx;
              mem_wdata        = wdata;
              lock_d[addr_idx] = lock;
            end
          end else begin
            rvalid_d = 1'b1;
            rd_ok_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      idx_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_ok_q  <= rd_ok_d;
      lock_q   <= lock_d;
    end
  end

  // No reset on the array: INIT rewrites every entry after each reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    mem_rd_q <= mem[addr_idx];
  end

  assign ready  = (state_q == ST_IDLE);
  assign busy   = (state_q == ST_INIT);
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rd_ok_q ? mem_rd_q : '0;

`ifdef PROTECTED_REGFILE_VIOL_CNT_EN
  logic [7:0] viol_q, viol_d;

  always_comb begin
    viol_d = viol_q;
    if (err_q && (viol_q != 8'hFF)) begin
      viol_d = viol_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      viol_q <= 8'd0;
    end else begin
      viol_q <= viol_d;
    end
  end

  assign viol_count = viol_q;
`else
  assign viol_count = 8'd0;
`endif

endmodule

// File: tb/tb_protected_regfile.sv
module tb_protected_regfile;

  logic        clk;
  logic        reset;
  logic        req;
  logic        write;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        busy;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [7:0]  viol_count;

  int checks = 0;
  int errors = 0;

`ifdef PROTECTED_REGFILE_VIOL_CNT_EN
  localparam bit VIOL_EN = 1'b1;
`else
  localparam bit VIOL_EN = 1'b0;
`endif

  protected_regfile dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .write      (write),
    .lock       (lock),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .busy       (busy),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .err        (err),
    .viol_count (viol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write transaction; err is checked in the cycle after acceptance.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic lk, input logic exp_err);
    req = 1'b1; write = 1'b1; lock = lk; addr = a; wdata = d;
    tick();
    req = 1'b0; write = 1'b0; lock = 1'b0;
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    $display("write addr=%h data=%h lock=%0d -> err=%0d", a, d, lk, err);
  endtask

  // One read transaction; response is checked one cycle after acceptance.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_data,
                         input logic exp_err);
    req = 1'b1; write = 1'b0; lock = 1'b0; addr = a;
    tick();
    req = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, "_rdata"}, rdata, exp_data);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    $display("read  addr=%h -> rvalid=%0d rdata=%h err=%0d", a, rvalid, rdata, err);
  endtask

  // Counts cycles with busy=1 (bounded), then expects ready.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'd32);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    $display("init done after %0d busy cycles", n);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_viol"}, 32'(viol_count), 32'd0);
    $display("reset pulse (%s)", tag);
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; write = 1'b0; lock = 1'b0; addr = '0; wdata = '0;

    // Reset, initialisation length and key contents
    pulse_reset("rst0");
    wait_init("init0");
    do_read("key0", 32'd0, 32'h1035_9987, 1'b0);
    do_read("key1", 32'd1, 32'h1035_9988, 1'b0);
    do_read("e5_zero", 32'd5, 32'h0, 1'b0);

    // Key region is write-protected
    do_write("wkey0", 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    do_read("key0_keep", 32'd0, 32'h1035_9987, 1'b0);
    chk("viol_one", 32'(viol_count), VIOL_EN ? 32'd1 : 32'd0);

    // Lock on write, then a rejected overwrite
    do_write("w7_lock", 32'd7, 32'h0000_00AA, 1'b1, 1'b0);
    do_write("w7_locked", 32'd7, 32'h0000_00BB, 1'b0, 1'b1);
    do_read("r7_aa", 32'd7, 32'h0000_00AA, 1'b0);

    // Out-of-range addresses, no aliasing into low entries
    do_write("w_oor20", 32'h0000_0020, 32'h0000_0011, 1'b0, 1'b1);
    do_write("w_oor8m", 32'h8000_0000, 32'h0000_0022, 1'b0, 1'b1);
    do_write("w_oor25", 32'h0000_0025, 32'h0000_0033, 1'b1, 1'b1);
    do_read("r_oor20", 32'h0000_0020, 32'h0, 1'b1);
    do_read("r5_intact", 32'd5, 32'h0, 1'b0);
    do_write("w5_unlocked", 32'd5, 32'h0000_0044, 1'b0, 1'b0);
    do_read("r5_new", 32'd5, 32'h0000_0044, 1'b0);

    // Back-to-back write then read, no bubble
    do_write("w3", 32'd3, 32'h0000_1234, 1'b0, 1'b0);
    chk("b2b_ready", 32'(ready), 32'd1);
    do_read("r3_b2b", 32'd3, 32'h0000_1234, 1'b0);

    // Reset clears user locks and contents
    pulse_reset("rst1");
    wait_init("init1");
    do_read("r7_after_rst", 32'd7, 32'h0, 1'b0);
    do_write("w7_again", 32'd7, 32'h0000_0055, 1'b0, 1'b0);
    do_read("r7_55", 32'd7, 32'h0000_0055, 1'b0);

    // Reset in the middle of INIT restarts it
    pulse_reset("rst2");
    repeat (9) tick();
    chk("mid_init_busy", 32'(busy), 32'd1);
    pulse_reset("rst3");
    wait_init("init3");

    // 300 back-to-back rejected writes saturate the violation counter
    req = 1'b1; write = 1'b1; lock = 1'b1; addr = 32'd0; wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 300; i++) begin
      tick();
      chk("sat_err", 32'(err), 32'd1);
    end
    req = 1'b0; write = 1'b0; lock = 1'b0;
    tick();
    chk("viol_sat", 32'(viol_count), VIOL_EN ? 32'hFF : 32'd0);
    $display("300 locked writes -> viol_count=%h", viol_count);
    tick();
    chk("viol_hold", 32'(viol_count), VIOL_EN ? 32'hFF : 32'd0);
    do_read("key0_final", 32'd0, 32'h1035_9987, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
